// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Brief    : 16x-oversampled 8-bit async serial receiver with ack handshake.
//            Define SERIAL_RX_PARITY_EN to add one even-parity bit per frame.
// Revision : 1.0
// ============================================================================
module serial_rx #(
   parameter int DIV = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RxD,
   input  logic       int_ack,
   output logic       int_req,
   output logic [7:0] data_out,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy
);
   localparam logic [15:0] c_div_reload  = 16'(DIV - 1);
   localparam logic [3:0]  c_sample_tick = 4'd7;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_sync;
   logic [1:0]  r_sync_vld;
   logic        r_armed;
   logic [15:0] r_div_cnt;
   logic [3:0]  r_tick_cnt;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic        w_rxd;
   logic        w_tick;
   logic        w_sample;
   logic        w_start;
   logic        w_stop_smp;
   logic        w_par_bad;

   assign w_rxd      = r_sync[1];
   assign w_tick     = (r_div_cnt == 16'd0);
   assign w_sample   = (r_state != IDLE) && w_tick && (r_tick_cnt == c_sample_tick);
   // A start needs a high level seen since reset or since the last frame,
   // so a break or a line held low across reset never retriggers.
   assign w_start    = (r_state == IDLE) && r_armed && !w_rxd;
   assign w_stop_smp = (r_state == STOP) && w_sample;
   assign rx_busy    = (r_state != IDLE);

`ifdef SERIAL_RX_PARITY_EN
   logic r_par_err;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_par_err <= 1'b0;
      end else if (w_start) begin
         r_par_err <= 1'b0;
      end else if (r_state == PARITY && w_sample) begin
         r_par_err <= (w_rxd != ^r_shift);
      end
   end
   assign w_par_bad = r_par_err;
`else
   assign w_par_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:   if (w_start) w_state_nxt = START;
         START:  if (w_sample) w_state_nxt = w_rxd ? IDLE : DATA;
         DATA: begin
            if (w_sample && r_bit_cnt == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
               w_state_nxt = PARITY;
`else
               w_state_nxt = STOP;
`endif
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         PARITY: if (w_sample) w_state_nxt = STOP;
`endif
         STOP:   if (w_sample) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync     <= 2'b11;
         r_sync_vld <= 2'b00;
         r_armed    <= 1'b0;
         r_div_cnt  <= 16'd0;
         r_tick_cnt <= 4'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
      end else begin
         r_sync     <= {r_sync[0], RxD};
         r_sync_vld <= {r_sync_vld[0], 1'b1};
         if (w_start)
            r_armed <= 1'b0;
         else if (r_state == IDLE && r_sync_vld[1] && w_rxd)
            r_armed <= 1'b1;

         // Tick phase restarts at the detected edge so tick 8 lands mid-bit.
         if (w_start) begin
            r_div_cnt  <= c_div_reload;
            r_tick_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
         end else if (r_state != IDLE) begin
            if (w_tick) begin
               r_div_cnt  <= c_div_reload;
               r_tick_cnt <= r_tick_cnt + 4'd1;
            end else begin
               r_div_cnt  <= r_div_cnt - 16'd1;
            end
         end

         if (r_state == DATA && w_sample) begin
            r_shift   <= {w_rxd, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_req   <= 1'b0;
         data_out  <= 8'h00;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (int_ack) begin
            int_req   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end
         // Completion events override the ack clear issued in the same cycle.
         if (w_stop_smp) begin
            if (!w_rxd || w_par_bad) begin
               frame_err <= 1'b1;
            end else if (!int_req || int_ack) begin
               data_out <= r_shift;
               int_req  <= 1'b1;
            end else begin
               overrun  <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// Bench for serial_rx at DIV=1: frames driven bit by bit, expected receiver
// state pushed to a scoreboard queue and compared once the frame completes.
module tb_serial_rx;
   localparam int c_bit_clks = 16;
`ifdef SERIAL_RX_PARITY_EN
   localparam int c_nbits = 11;
`else
   localparam int c_nbits = 10;
`endif
   // drive-cycle index of the stop-bit sample edge (2 sync + 8 ticks into stop)
   localparam int c_stop_k = (c_nbits - 1) * c_bit_clks + 10;

   typedef struct packed {
      logic [7:0] data;
      logic       req;
      logic       fe;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       RxD;
   logic       int_ack;
   logic       int_req;
   logic [7:0] data_out;
   logic       frame_err;
   logic       overrun;
   logic       rx_busy;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   rise_cyc = 0;
   logic prev_req = 1'b0;
   exp_t sb_q[$];

   logic [7:0] m_data;
   logic       m_req, m_fe, m_ov;

   serial_rx #(.DIV(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .RxD       (RxD),
      .int_ack   (int_ack),
      .int_req   (int_req),
      .data_out  (data_out),
      .frame_err (frame_err),
      .overrun   (overrun),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (int_req && !prev_req) rise_cyc = cyc;
      prev_req = int_req;
   end

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_data = 8'h00; m_req = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] d, input logic stop_ok,
                              input logic par_ok, input logic ack);
      if (ack) begin m_req = 1'b0; m_fe = 1'b0; m_ov = 1'b0; end
      if (!stop_ok || !par_ok) m_fe = 1'b1;
      else if (!m_req) begin m_data = d; m_req = 1'b1; end
      else m_ov = 1'b1;
   endtask

   task automatic sb_push();
      exp_t e;
      e.data = m_data; e.req = m_req; e.fe = m_fe; e.ov = m_ov;
      sb_q.push_back(e);
   endtask

   task automatic sb_compare(input string tag, input int settle);
      exp_t e;
      repeat (settle) @(negedge clk);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_value({tag, "_data"}, 32'(data_out), 32'(e.data));
         check_value({tag, "_req"},  32'(int_req),  32'(e.req));
         check_value({tag, "_fe"},   32'(frame_err), 32'(e.fe));
         check_value({tag, "_ov"},   32'(overrun),  32'(e.ov));
         check_value({tag, "_busy"}, 32'(rx_busy),  32'd0);
      end
   endtask

   // rst_k >= 0 pulses reset low for 3 clocks at that drive cycle.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit,
                             input logic ack_at_stop, input int rst_k);
      logic [10:0] bits;
`ifdef SERIAL_RX_PARITY_EN
      bits = {stop_bit, par_bit, d, 1'b0};
`else
      bits = {par_bit, stop_bit, d, 1'b0};
`endif
      @(negedge clk);
      start_cyc = cyc;
      rise_cyc  = 0;
      for (int k = 0; k < c_nbits * c_bit_clks; k++) begin
         if (k > 0) @(negedge clk);
         RxD     = bits[k / c_bit_clks];
         int_ack = ack_at_stop && (k == c_stop_k);
         if (k == rst_k) begin
            check_value("busy_midframe", 32'(rx_busy), 32'd1);
            rst = 1'b0;
            #1;
            check_value("rst_busy", 32'(rx_busy), 32'd0);
            check_value("rst_req",  32'(int_req), 32'd0);
            check_value("rst_data", 32'(data_out), 32'd0);
         end
         if (k == rst_k + 3) rst = 1'b1;
      end
      @(negedge clk);
      RxD = 1'b1; int_ack = 1'b0;
   endtask

   task automatic ack_pulse(input string tag);
      @(negedge clk); int_ack = 1'b1;
      @(negedge clk); int_ack = 1'b0;
      m_req = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
      sb_push();
      sb_compare(tag, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; RxD = 1'b1; int_ack = 1'b0;
      model_reset();
      #12;
      check_value("reset_req",  32'(int_req),   32'd0);
      check_value("reset_data", 32'(data_out),  32'd0);
      check_value("reset_fe",   32'(frame_err), 32'd0);
      check_value("reset_ov",   32'(overrun),   32'd0);
      check_value("reset_busy", 32'(rx_busy),   32'd0);
      @(negedge clk); rst = 1'b1;
      repeat (4) @(negedge clk);

      send_frame(8'hA5, 1'b1, ^8'hA5, 1'b0, -1);
      model_frame(8'hA5, 1'b1, 1'b1, 1'b0); sb_push();
      check_value("a5_latency", 32'(rise_cyc - start_cyc), 32'(c_stop_k + 1));
      sb_compare("a5", 3);
      ack_pulse("ack_a5");

      @(negedge clk); RxD = 1'b0;
      repeat (4) @(negedge clk);
      RxD = 1'b1;
      sb_push();
      sb_compare("glitch", 20);

      send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0, -1);
      model_frame(8'h3C, 1'b0, 1'b1, 1'b0); sb_push();
      sb_compare("stop_low", 3);
      ack_pulse("ack_fe");

      send_frame(8'h11, 1'b1, ^8'h11, 1'b0, -1);
      model_frame(8'h11, 1'b1, 1'b1, 1'b0); sb_push();
      sb_compare("f11", 3);
      send_frame(8'h22, 1'b1, ^8'h22, 1'b0, -1);
      model_frame(8'h22, 1'b1, 1'b1, 1'b0); sb_push();
      sb_compare("f22_overrun", 3);
      ack_pulse("ack_ov");

      send_frame(8'h66, 1'b1, ^8'h66, 1'b0, -1);
      model_frame(8'h66, 1'b1, 1'b1, 1'b0); sb_push();
      sb_compare("f66", 3);
      send_frame(8'h77, 1'b1, ^8'h77, 1'b1, -1);
      model_frame(8'h77, 1'b1, 1'b1, 1'b1); sb_push();
      sb_compare("f77_ack_at_stop", 3);
      ack_pulse("ack_77");

      send_frame(8'hE0, 1'b1, ^8'hE0, 1'b0, 5 * c_bit_clks + 8);
      model_reset(); sb_push();
      sb_compare("rst_abort", 20);

`ifdef SERIAL_RX_PARITY_EN
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0, -1);
      model_frame(8'h5A, 1'b1, 1'b0, 1'b0); sb_push();
      sb_compare("f5a_bad_parity", 3);
`else
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
      model_frame(8'h5A, 1'b1, 1'b1, 1'b0); sb_push();
      sb_compare("f5a", 3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
- REQ-001 SHALL have parameter DIV, default 27: clocks per 1/16-bit oversample tick (50 MHz, 115200 baud); legal range 1..65535.
- REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
- REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
- REQ-004 SHALL have port RxD  input  1  asynchronous serial line, idle high.
- REQ-005 SHALL have port int_ack  input  1  CPU acknowledge of received byte.
- REQ-006 SHALL have port int_req  output  1  byte available, held until acknowledged.
- REQ-007 SHALL have port data_out  output  8  last accepted byte.
- REQ-008 SHALL have port frame_err  output  1  sticky: stop bit sampled low (or parity bad).
- REQ-009 SHALL have port overrun  output  1  sticky: byte completed while int_req=1.
- REQ-010 SHALL have port rx_busy  output  1  high whenever FSM is not IDLE.

Function
- REQ-011 SHALL pass RxD through a 2-flop synchroniser (reset value 1); all sampling uses the synchronised value.
- REQ-012 SHALL generate an oversample tick every DIV clocks from a down-counter reloaded on entry to START, so tick phase aligns to the detected edge.
- REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY (macro only), STOP.
- REQ-014 IDLE->START on synchronised RxD high-to-low transition.
- REQ-015 START: at tick 8, RxD low -> DATA; RxD high -> IDLE (glitch rejected, no flag set).
- REQ-016 DATA: sample at tick 8 of each of 8 bit periods (16 ticks apart), LSB first into shift register; 3-bit bit counter; after bit 7 -> PARITY or STOP.
- REQ-017 STOP: sample at tick 8 of stop period; FSM returns to IDLE on the clock after the sample (no wait for full stop bit).
- REQ-018 Stop sampled high, int_req=0 or int_ack=1 same cycle: data_out <= shift register, int_req <= 1.
- REQ-019 Stop sampled high, int_req=1 and int_ack=0: byte discarded, data_out unchanged, overrun <= 1.
- REQ-020 Stop sampled low: byte discarded, frame_err <= 1, int_req unchanged; FSM returns to IDLE and re-arms only after RxD seen high (break does not restart reception).
- REQ-021 int_ack=1 with no completing byte: int_req, frame_err, overrun cleared next clock; int_ack while int_req=0 clears flags only.
- REQ-022 Latency: int_req rises 1 clock after the stop-bit sample tick.

Reset
- REQ-023 Asserting rst (low) SHALL immediately force: FSM IDLE, int_req=0, data_out=8'h00, frame_err=0, overrun=0, rx_busy=0, synchroniser=2'b11, counters 0.
- REQ-024 Reset mid-frame SHALL abandon the frame; after release, reception starts only at the next high-to-low edge.

Configuration
- REQ-025 Macro SERIAL_RX_PARITY_EN defined: one even-parity bit after bit 7 sampled in PARITY state; mismatch sets frame_err and discards byte (stop still sampled, not delivered).
- REQ-026 Macro undefined: PARITY state absent, frame is 10 bits (start, 8 data, stop).

Verification (DIV=1, bit = 16 clocks)
- REQ-027 Frame 8'hA5, good stop -> data_out=8'hA5, int_req=1 one clock after stop sample, frame_err=0, overrun=0.
- REQ-028 RxD low pulse of 4 clocks from idle -> FSM back to IDLE, int_req=0, no flags.
- REQ-029 Frame 8'h3C with stop bit low -> frame_err=1, data_out unchanged, int_req=0.
- REQ-030 Two frames 8'h11 then 8'h22, no int_ack -> data_out=8'h11, overrun=1; int_ack pulse -> int_req=0, overrun=0 next clock.
- REQ-031 int_ack asserted exactly on stop-sample cycle of second frame 8'h77 -> data_out=8'h77, int_req stays 1, overrun=0.
- REQ-032 rst low at bit 4 of a frame, released, then frame 8'h5A -> only 8'h5A delivered; with SERIAL_RX_PARITY_EN, 8'h5A with parity 1 -> frame_err=1, no delivery.
